// File: rtl/fetch_pkg.sv
// Shared constants and state type for the program-fetch front end.
package fetch_pkg;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;
    localparam int         LUT_DEPTH  = 8;
    localparam int         LUT_AW     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Eight-entry branch-target table: synchronous write, asynchronous read.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);

    logic [PC_W-1:0] mem [LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, Start/Done handshake and branch resolution for the single-cycle core.
//
//   state | meaning
//   IDLE  | after reset; branch LUT writable; waiting for Start
//   RUN   | one instruction per cycle; Running qualifies writes
//   DONE  | halted or ran off the top of ROM; PC/count frozen
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int IW    = 9,
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic [IW-1:0]     Instr,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              LutWe,
    input  logic [LUT_AW-1:0] LutAddr,
    input  logic [PC_W-1:0]   LutData,
    output logic [PC_W-1:0]   ProgCtr,
    output logic [2:0]        Opcode,
    output logic              Running,
    output logic              Done,
    output logic [CNT_W-1:0]  CycleCnt
);

    localparam logic [IW-1:0]   HALT    = IW'(HALT_INSTR);
    localparam logic [PC_W-1:0] PC_LAST = '1;

    fetch_state_t      state, state_next;
    logic [PC_W-1:0]   pc_next;
    logic [CNT_W-1:0]  cnt_next;
    logic [PC_W-1:0]   target;
    logic              is_halt;
    logic              taken;
    logic              lut_we;

    assign is_halt = (Instr == HALT);
    assign taken   = Branch & Zero;
    assign lut_we  = LutWe && (state == IDLE);
    assign Opcode  = Instr[IW-1:IW-3];

    branch_lut #(.PC_W(PC_W)) u_lut (
        .clk   (Clk),
        .reset (Reset),
        .we    (lut_we),
        .waddr (LutAddr),
        .wdata (LutData),
        .raddr (Instr[2:0]),
        .rdata (target)
    );

    always_comb begin
        state_next = state;
        pc_next    = ProgCtr;
        cnt_next   = CycleCnt;
        Running    = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                Done = (state == DONE);
                if (Start) begin
                    state_next = RUN;
                    pc_next    = StartAddr;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (is_halt) begin
                    state_next = DONE;
                end else begin
                    Running = 1'b1;
                    if (CycleCnt != '1) begin
                        cnt_next = CycleCnt + CNT_W'(1);
                    end
                    // A taken branch wins even at the top address; only sequential fetch stops there.
                    if (taken) begin
                        pc_next = target;
                    end else if (ProgCtr == PC_LAST) begin
                        state_next = DONE;
                    end else begin
                        pc_next = ProgCtr + PC_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            ProgCtr  <= '0;
            CycleCnt <= '0;
        end else begin
            state    <= state_next;
            ProgCtr  <= pc_next;
            CycleCnt <= cnt_next;
        end
    end

endmodule
